maxnet_converge_monitor: RTL
============================

Name: maxnet_converge_monitor

Overview:
- Sequential, parametrised termination detector for the Maxnet iteration loop. Supersedes the fixed 4-input combinational "at most one non-zero" check.
- Samples N signed activations once per iteration over a valid/ready handshake and counts survivors.
- Declares convergence when at most one activation survives and reports the winner index and value.
- Flags a timeout when the iteration budget runs out first. Sits between the Maxnet datapath and the top-level controller.

Parameters:
- N, 4, number of activation channels (>=2).
- W, 32, activation width in bits, signed two's complement.
- MAX_ITER, 255, iteration budget before timeout (>=1).
- IDX_W, $clog2(N), width of winner index.
- ITER_W, $clog2(MAX_ITER+1), width of iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a run.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  monitor can accept a vector.
- in_data  in  N*W  packed activations; channel i is in_data[i*W +: W].
- done  out  1  run finished; level signal, held until next start.
- converged  out  1  done due to survivors <= 1.
- timeout  out  1  done due to budget exhausted.
- none_alive  out  1  converged with zero survivors.
- winner_idx  out  IDX_W  index of the surviving channel.
- winner_val  out  W  activation of the surviving channel.
- survivors  out  IDX_W+1  alive count of the last accepted vector.
- iter_count  out  ITER_W  number of vectors accepted this run.

Behaviour:
- Alive definition: channel is alive iff its signed value > 0. Zero and negative values count as dead; Maxnet clamps to zero.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including in_ready=0 and winner_val=0.
  - Reset mid-run abandons the run with no residual flags.
- States:
  - IDLE: in_ready=0. On start, go to RUN and clear iter_count, done, converged, timeout, none_alive, survivors, winner_idx and winner_val.
  - RUN: in_ready=1. A handshake occurs on in_valid & in_ready. On each handshake:
    - iter_count increments; survivors registers the alive count.
    - If count <= 1: go to DONE with converged=1. winner_idx/winner_val take the lowest-index alive channel. If count == 0, set none_alive=1 and winner_idx=0, winner_val=0.
    - Else if the new iter_count == MAX_ITER: go to DONE with timeout=1. winner_idx/winner_val are taken from the lowest-index alive channel as best guess.
    - Else stay in RUN.
  - DONE: in_ready=0 and done=1. All result outputs hold. On start, go to RUN with the same clearing as from IDLE.
- Latency: results and done are registered and appear the cycle after the accepting handshake. in_ready drops in that same cycle, so no second vector is accepted.
- Simultaneous events:
  - start in RUN restarts: counters and flags clear, and any in_valid in that cycle is NOT accepted (start has priority).
  - Convergence on the MAX_ITER-th vector reports converged=1, timeout=0 (convergence has priority).
- Ties: two or more equal positive values never converge and end in timeout.
- in_valid held while in_ready=0 is ignored. in_data is only sampled on a handshake.
- iter_count saturates at MAX_ITER by construction; it never wraps.

Decomposition:
- Package maxnet_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default constants for N, W and MAX_ITER;
  - the alive predicate as a function (value > 0).
- Sub-module maxnet_alive_scan is purely combinational over N channels. It outputs the alive count (IDX_W+1 bits), the lowest alive index, an any-alive bit, and the selected value.
- The top level holds the FSM, the counter and the output registers.

Test Plan:
- Reset/idle: drive rst_n=0 mid-RUN at iter_count=3 -> all outputs 0 immediately; after release, in_ready=0 until start.
- Single survivor: N=4; start, then vectors {5,3,2,1}, {4,1,0,-2}, {3,0,0,0} -> done and converged one cycle after the 3rd handshake; winner_idx=0, winner_val=3, iter_count=3, survivors=1.
- All dead: start; vector {0,-1,0,-7} -> converged=1, none_alive=1, winner_idx=0, survivors=0, iter_count=1.
- Timeout: MAX_ITER=4; feed {2,2,0,0} four times -> timeout=1, converged=0, iter_count=4, winner_idx=0; a 5th in_valid is not accepted (in_ready=0).
- Priority at boundary: MAX_ITER=2; vectors {3,1,0,0} then {0,0,9,0} -> converged=1, timeout=0, winner_idx=2, winner_val=9.
- Restart: start asserted in RUN together with in_valid at iter_count=2 -> vector not accepted, iter_count=0; next vector counts as iteration 1. Also start in DONE clears done the following cycle.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the Maxnet convergence monitor.
// Holds the FSM state encoding, default sizing constants and the alive predicate.
package maxnet_pkg;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 32;
  localparam int MAX_ITER_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A channel survives only when strictly positive; Maxnet clamps losers to zero.
  function automatic logic is_alive(input logic sign_bit, input logic nonzero);
    return !sign_bit && nonzero;
  endfunction

endpackage

// File: rtl/maxnet_alive_scan.sv
// Combinational scan of N signed activations: alive count plus the
// lowest-index alive channel and its value (zero when nothing is alive).
module maxnet_alive_scan
  import maxnet_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N*W-1:0] data,
  output logic [IDX_W:0]   alive_cnt,
  output logic [IDX_W-1:0] low_idx,
  output logic             any_alive,
  output logic [W-1:0]     low_val
);

  always_comb begin
    alive_cnt = '0;
    low_idx   = '0;
    any_alive = 1'b0;
    low_val   = '0;
    // Walk from the top so the lowest alive channel is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (is_alive(data[i*W + W - 1], |data[i*W +: W])) begin
        alive_cnt = alive_cnt + (IDX_W + 1)'(1);
        low_idx   = IDX_W'(i);
        any_alive = 1'b1;
        low_val   = data[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/maxnet_converge_monitor.sv
// Maxnet termination detector: accepts one activation vector per iteration,
// ends the run on <=1 survivor (converged) or on the iteration budget (timeout).
module maxnet_converge_monitor
  import maxnet_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int IDX_W    = $clog2(N),
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic              done,
  output logic              converged,
  output logic              timeout,
  output logic              none_alive,
  output logic [IDX_W-1:0]  winner_idx,
  output logic [W-1:0]      winner_val,
  output logic [IDX_W:0]    survivors,
  output logic [ITER_W-1:0] iter_count
);

  // Handshake: a vector is taken on a rising edge with in_valid & in_ready and
  // no start; in_ready is high only in RUN and drops the cycle after a final vector.

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              tmo_q, tmo_d;
  logic              none_q, none_d;
  logic [IDX_W:0]    surv_q, surv_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [W-1:0]      wval_q, wval_d;

  logic [IDX_W:0]    scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic              scan_any;
  logic [W-1:0]      scan_val;

  maxnet_alive_scan #(.N(N), .W(W), .IDX_W(IDX_W)) u_scan (
    .data      (in_data),
    .alive_cnt (scan_cnt),
    .low_idx   (scan_idx),
    .any_alive (scan_any),
    .low_val   (scan_val)
  );

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    tmo_d   = tmo_q;
    none_d  = none_q;
    surv_d  = surv_q;
    widx_d  = widx_q;
    wval_d  = wval_q;
    if (start) begin
      // Start wins over any same-cycle handshake, from every state.
      state_d = RUN;
      iter_d  = '0;
      conv_d  = 1'b0;
      tmo_d   = 1'b0;
      none_d  = 1'b0;
      surv_d  = '0;
      widx_d  = '0;
      wval_d  = '0;
    end else if (state_q == RUN && in_valid) begin
      iter_d = iter_q + ITER_W'(1);
      surv_d = scan_cnt;
      widx_d = scan_idx;
      wval_d = scan_val;
      if (scan_cnt <= (IDX_W + 1)'(1)) begin
        state_d = DONE;
        conv_d  = 1'b1;
        none_d  = !scan_any;
      end else if (iter_d == ITER_W'(MAX_ITER)) begin
        state_d = DONE;
        tmo_d   = 1'b1;
      end
    end else if (state_q != RUN && state_q != DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
      none_q  <= 1'b0;
      surv_q  <= '0;
      widx_q  <= '0;
      wval_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      tmo_q   <= tmo_d;
      none_q  <= none_d;
      surv_q  <= surv_d;
      widx_q  <= widx_d;
      wval_q  <= wval_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign converged  = conv_q;
  assign timeout    = tmo_q;
  assign none_alive = none_q;
  assign winner_idx = widx_q;
  assign winner_val = wval_q;
  assign survivors  = surv_q;
  assign iter_count = iter_q;

endmodule
